// File: rtl/sensing_filter_multi.sv
// Multi-channel ADC block averager with per-channel offset, gain, saturation
// and sticky over-limit flags; three-stage pipeline, one result per cycle.
module sensing_filter_multi #(
    parameter int N_CH     = 2,
    parameter int ADC_W    = 8,
    parameter int AVG_LOG2 = 4,
    parameter int GAIN_W   = 16,
    parameter int SHIFT    = 4,
    parameter int OUT_W    = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    i_valid,
    input  logic [2:0]              i_ch,
    input  logic [ADC_W-1:0]        i_sample,
    input  logic [N_CH*ADC_W-1:0]   i_offset,
    input  logic [N_CH*GAIN_W-1:0]  i_gain,
    input  logic [N_CH*OUT_W-1:0]   i_limit,
    input  logic                    i_clear,
    output logic                    o_valid,
    output logic [2:0]              o_ch,
    output logic [OUT_W-1:0]        o_data,
    output logic [N_CH*OUT_W-1:0]   o_data_all,
    output logic [N_CH-1:0]         o_fault
);

    localparam int AW    = ADC_W + AVG_LOG2;
    localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int DW    = ADC_W + 1;
    localparam int PW    = DW + GAIN_W + 1;
    localparam int CW    = ((PW > OUT_W) ? PW : OUT_W) + 1;

    logic [AW-1:0]    acc_q [N_CH];
    logic [AW-1:0]    acc_d [N_CH];
    logic [CNT_W-1:0] cnt_q [N_CH];
    logic [CNT_W-1:0] cnt_d [N_CH];

    logic             s0_valid_q, s0_valid_d;
    logic [2:0]       s0_ch_q, s0_ch_d;
    logic [ADC_W-1:0] s0_avg_q, s0_avg_d;

    logic                 s1_valid_q, s1_valid_d;
    logic [2:0]           s1_ch_q, s1_ch_d;
    logic signed [DW-1:0] s1_diff_q, s1_diff_d;

    logic                    o_valid_q, o_valid_d;
    logic [2:0]              o_ch_q, o_ch_d;
    logic signed [OUT_W-1:0] o_data_q, o_data_d;
    logic [N_CH*OUT_W-1:0]   all_q, all_d;
    logic [N_CH-1:0]         fault_q, fault_d;

    logic                    accept, last;
    logic [AW-1:0]           sel_acc, sum;
    logic [CNT_W-1:0]        sel_cnt;
    logic [ADC_W-1:0]        sel_off;
    logic [GAIN_W-1:0]       sel_gain;
    logic signed [OUT_W-1:0] sel_lim, sat;
    logic signed [PW-1:0]    prod, shifted;
    logic signed [CW-1:0]    wide, max_c, min_c;

    // Stage 0: accumulate; a block completes on the counter's all-ones value
    always_comb begin
        sel_acc = '0;
        sel_cnt = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (i_ch == 3'(k)) begin
                sel_acc = acc_q[k];
                sel_cnt = cnt_q[k];
            end
        end
        accept = i_valid && ({1'b0, i_ch} < 4'(N_CH));
        sum    = sel_acc + AW'(i_sample);
        last   = (AVG_LOG2 == 0) || (&sel_cnt);
        for (int k = 0; k < N_CH; k++) begin
            acc_d[k] = acc_q[k];
            cnt_d[k] = cnt_q[k];
            if (accept && i_ch == 3'(k)) begin
                acc_d[k] = last ? '0 : sum;
                cnt_d[k] = last ? '0 : sel_cnt + CNT_W'(1);
            end
        end
        s0_valid_d = accept && last;
        s0_ch_d    = s0_ch_q;
        s0_avg_d   = s0_avg_q;
        if (accept && last) begin
            s0_ch_d  = i_ch;
            s0_avg_d = sum[AW-1:AVG_LOG2];
        end
    end

    always_comb begin
        sel_off = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (s0_ch_q == 3'(k)) sel_off = i_offset[k*ADC_W +: ADC_W];
        end
        s1_valid_d = s0_valid_q;
        s1_ch_d    = s0_valid_q ? s0_ch_q : s1_ch_q;
        s1_diff_d  = s1_diff_q;
        if (s0_valid_q) begin
            s1_diff_d = $signed({1'b0, s0_avg_q}) - $signed({1'b0, sel_off});
        end
    end

    // Stage 2: full-precision product, floor shift, clamp to OUT_W
    always_comb begin
        sel_gain = '0;
        sel_lim  = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (s1_ch_q == 3'(k)) begin
                sel_gain = i_gain[k*GAIN_W +: GAIN_W];
                sel_lim  = $signed(i_limit[k*OUT_W +: OUT_W]);
            end
        end
        prod    = PW'(s1_diff_q) * PW'($signed({1'b0, sel_gain}));
        shifted = prod >>> SHIFT;
        wide    = CW'(shifted);
        max_c   = {{(CW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
        min_c   = {{(CW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
        if (wide > max_c)      sat = max_c[OUT_W-1:0];
        else if (wide < min_c) sat = min_c[OUT_W-1:0];
        else                   sat = wide[OUT_W-1:0];

        o_valid_d = s1_valid_q;
        o_ch_d    = s1_valid_q ? s1_ch_q : o_ch_q;
        o_data_d  = s1_valid_q ? sat : o_data_q;
        all_d     = all_q;
        fault_d   = i_clear ? '0 : fault_q;
        for (int k = 0; k < N_CH; k++) begin
            if (s1_valid_q && s1_ch_q == 3'(k)) begin
                all_d[k*OUT_W +: OUT_W] = sat;
                if (sat > sel_lim) fault_d[k] = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < N_CH; k++) begin
                acc_q[k] <= '0;
                cnt_q[k] <= '0;
            end
            s0_valid_q <= 1'b0;
            s0_ch_q    <= '0;
            s0_avg_q   <= '0;
            s1_valid_q <= 1'b0;
            s1_ch_q    <= '0;
            s1_diff_q  <= '0;
            o_valid_q  <= 1'b0;
            o_ch_q     <= '0;
            o_data_q   <= '0;
            all_q      <= '0;
            fault_q    <= '0;
        end else begin
            for (int k = 0; k < N_CH; k++) begin
                acc_q[k] <= acc_d[k];
                cnt_q[k] <= cnt_d[k];
            end
            s0_valid_q <= s0_valid_d;
            s0_ch_q    <= s0_ch_d;
            s0_avg_q   <= s0_avg_d;
            s1_valid_q <= s1_valid_d;
            s1_ch_q    <= s1_ch_d;
            s1_diff_q  <= s1_diff_d;
            o_valid_q  <= o_valid_d;
            o_ch_q     <= o_ch_d;
            o_data_q   <= o_data_d;
            all_q      <= all_d;
            fault_q    <= fault_d;
        end
    end

    assign o_valid    = o_valid_q;
    assign o_ch       = o_ch_q;
    assign o_data     = o_data_q;
    assign o_data_all = all_q;
    assign o_fault    = fault_q;

endmodule

// File: tb/tb_sensing_filter_multi.sv
// Randomized bench for sensing_filter_multi: a block-average / scale model
// predicts every result, its cycle, the per-channel hold and the fault flags.
module tb_sensing_filter_multi;

    localparam int N_CH = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        i_valid = 1'b0;
    logic        i_clear = 1'b0;
    logic [2:0]  i_ch = '0;
    logic [7:0]  i_sample = '0;
    logic [7:0]  off [2];
    logic [15:0] gn [2];
    logic signed [15:0] lim [2];
    logic [15:0] i_offset;
    logic [31:0] i_gain;
    logic [31:0] i_limit;

    logic        o_valid, o0_valid;
    logic [2:0]  o_ch, o0_ch;
    logic [15:0] o_data, o0_data;
    logic [31:0] o_data_all, o0_data_all;
    logic [1:0]  o_fault, o0_fault;

    assign i_offset = {off[1], off[0]};
    assign i_gain   = {gn[1], gn[0]};
    assign i_limit  = {lim[1], lim[0]};

    sensing_filter_multi u_dut (
        .clock(clock), .reset(reset), .i_valid(i_valid), .i_ch(i_ch),
        .i_sample(i_sample), .i_offset(i_offset), .i_gain(i_gain),
        .i_limit(i_limit), .i_clear(i_clear), .o_valid(o_valid),
        .o_ch(o_ch), .o_data(o_data), .o_data_all(o_data_all),
        .o_fault(o_fault)
    );

    sensing_filter_multi #(.AVG_LOG2(0)) u_dut0 (
        .clock(clock), .reset(reset), .i_valid(i_valid), .i_ch(i_ch),
        .i_sample(i_sample), .i_offset(i_offset), .i_gain(i_gain),
        .i_limit(i_limit), .i_clear(i_clear), .o_valid(o0_valid),
        .o_ch(o0_ch), .o_data(o0_data), .o_data_all(o0_data_all),
        .o_fault(o0_fault)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;
    int pcyc = 0;

    int obs_cyc[$], obs_ch[$], obs_dat[$];
    int exp_cyc[$], exp_ch[$], exp_dat[$];
    int obs0_cyc[$], obs0_dat[$];
    int exp0_cyc[$], exp0_dat[$];

    int m_sum [2];
    int m_n   [2];
    int m_all [2];
    bit [1:0] m_fault;

    always @(posedge clock) pcyc <= pcyc + 1;

    always @(negedge clock) begin
        if (o_valid === 1'b1) begin
            obs_cyc.push_back(pcyc);
            obs_ch.push_back(int'(o_ch));
            obs_dat.push_back(int'($signed(o_data)));
        end
        if (o0_valid === 1'b1) begin
            obs0_cyc.push_back(pcyc);
            obs0_dat.push_back(int'($signed(o0_data)));
        end
    end

    // (mean - offset) * gain / 16, rounded toward minus infinity, clamped
    function automatic int scale(input int mean, input int o, input int g);
        longint p;
        p = longint'(mean - o) * longint'(g);
        p = p >>> 4;
        if (p > 32767) p = 32767;
        if (p < -32768) p = -32768;
        return int'(p);
    endfunction

    task automatic clear_model();
        for (int k = 0; k < 2; k++) begin
            m_sum[k] = 0;
            m_n[k]   = 0;
            m_all[k] = 0;
        end
        m_fault = '0;
        exp_cyc.delete(); exp_ch.delete(); exp_dat.delete();
        exp0_cyc.delete(); exp0_dat.delete();
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        clear_model();
        obs_cyc.delete(); obs_ch.delete(); obs_dat.delete();
        obs0_cyc.delete(); obs0_dat.delete();
    endtask

    task automatic send(input bit v, input int ch, input int s);
        int e;
        i_valid  = v;
        i_ch     = 3'(ch);
        i_sample = 8'(s);
        @(negedge clock);
        i_valid = 1'b0;
        if (v && ch < N_CH) begin
            e = scale(s, int'(off[ch]), int'(gn[ch]));
            exp0_cyc.push_back(pcyc + 2);
            exp0_dat.push_back(e);
            m_sum[ch] += s;
            m_n[ch]++;
            if (m_n[ch] == 16) begin
                e = scale(m_sum[ch] / 16, int'(off[ch]), int'(gn[ch]));
                exp_cyc.push_back(pcyc + 2);
                exp_ch.push_back(ch);
                exp_dat.push_back(e);
                m_all[ch] = e;
                if (e > int'(lim[ch])) m_fault[ch] = 1'b1;
                m_sum[ch] = 0;
                m_n[ch]   = 0;
            end
        end
    endtask

    task automatic test_reset();
        idle(2);
        checks++;
        if ({o_valid, o_ch, o_data, o_data_all, o_fault} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b ch=%0d d=%h all=%h f=%b, expected all zero",
                     o_valid, o_ch, o_data, o_data_all, o_fault);
        end
        checks++;
        if ({o0_valid, o0_data_all} !== '0) begin
            errors++;
            $display("FAIL reset_outputs_avg0: got v=%b all=%h, expected zero", o0_valid, o0_data_all);
        end
        reset = 1'b0;
        clear_model();
    endtask

    task automatic test_basic();
        int ec, ech, ed, oc, och, od;
        do_reset();
        off[0] = 8'd0; gn[0] = 16'd16; lim[0] = 16'sd32767;
        repeat (16) send(1'b1, 0, 100);
        idle(4);
        checks++;
        if (obs_cyc.size() !== 1 || exp_dat.size() !== 1) begin
            errors++;
            $display("FAIL basic_count: got %0d results, expected 1", obs_cyc.size());
        end
        while (exp_cyc.size() > 0 && obs_cyc.size() > 0) begin
            ec = exp_cyc.pop_front(); ech = exp_ch.pop_front(); ed = exp_dat.pop_front();
            oc = obs_cyc.pop_front(); och = obs_ch.pop_front(); od = obs_dat.pop_front();
            checks++;
            if ({oc, och, od} !== {ec, ech, ed} || od !== 100) begin
                errors++;
                $display("FAIL basic_result: got cyc=%0d ch=%0d d=%0d, expected cyc=%0d ch=%0d d=%0d",
                         oc, och, od, ec, ech, ed);
            end
        end
    endtask

    task automatic test_interleave();
        int ec, ech, ed, oc, och, od;
        do_reset();
        off[0] = 8'd0;   gn[0] = 16'd16; lim[0] = 16'sd32767;
        off[1] = 8'd152; gn[1] = 16'd23; lim[1] = 16'sd32767;
        for (int i = 0; i < 16; i++) begin
            send(1'b1, 0, 60 + (i % 3) - 1);
            send(1'b1, 1, 152);
        end
        idle(4);
        checks++;
        if (obs_cyc.size() !== exp_cyc.size()) begin
            errors++;
            $display("FAIL interleave_count: got %0d results, expected %0d", obs_cyc.size(), exp_cyc.size());
        end
        while (exp_cyc.size() > 0 && obs_cyc.size() > 0) begin
            ec = exp_cyc.pop_front(); ech = exp_ch.pop_front(); ed = exp_dat.pop_front();
            oc = obs_cyc.pop_front(); och = obs_ch.pop_front(); od = obs_dat.pop_front();
            checks++;
            if ({oc, och, od} !== {ec, ech, ed}) begin
                errors++;
                $display("FAIL interleave_result: got cyc=%0d ch=%0d d=%0d, expected cyc=%0d ch=%0d d=%0d",
                         oc, och, od, ec, ech, ed);
            end
        end
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (int'($signed(o_data_all[k*16 +: 16])) !== m_all[k]) begin
                errors++;
                $display("FAIL interleave_hold ch%0d: got %0d, expected %0d",
                         k, $signed(o_data_all[k*16 +: 16]), m_all[k]);
            end
        end
    endtask

    task automatic test_saturation();
        int ec, ech, ed, oc, och, od;
        do_reset();
        off[0] = 8'd0; gn[0] = 16'd65535; lim[0] = 16'sd32767;
        repeat (16) send(1'b1, 0, 255);
        idle(3);
        off[0] = 8'd255; gn[0] = 16'd1024;
        repeat (16) send(1'b1, 0, 0);
        idle(4);
        checks++;
        if (obs_cyc.size() !== 2) begin
            errors++;
            $display("FAIL sat_count: got %0d results, expected 2", obs_cyc.size());
        end
        while (exp_cyc.size() > 0 && obs_cyc.size() > 0) begin
            ec = exp_cyc.pop_front(); ech = exp_ch.pop_front(); ed = exp_dat.pop_front();
            oc = obs_cyc.pop_front(); och = obs_ch.pop_front(); od = obs_dat.pop_front();
            checks++;
            if ({oc, och, od} !== {ec, ech, ed}) begin
                errors++;
                $display("FAIL sat_result: got cyc=%0d ch=%0d d=%0d, expected cyc=%0d ch=%0d d=%0d",
                         oc, och, od, ec, ech, ed);
            end
        end
    endtask

    task automatic test_avg0();
        int ec, ed, oc, od;
        do_reset();
        off[0] = 8'd255; gn[0] = 16'd65535;
        send(1'b1, 0, 0);
        for (int i = 0; i < 20; i++) begin
            off[0] = 8'($urandom_range(0, 255)); gn[0] = 16'($urandom_range(0, 65535));
            off[1] = 8'($urandom_range(0, 255)); gn[1] = 16'($urandom_range(0, 65535));
            send($urandom_range(0, 3) != 0, $urandom_range(0, 2), $urandom_range(0, 255));
            idle(2);
        end
        idle(4);
        checks++;
        if (obs0_cyc.size() !== exp0_cyc.size()) begin
            errors++;
            $display("FAIL avg0_count: got %0d results, expected %0d", obs0_cyc.size(), exp0_cyc.size());
        end
        checks++;
        if (obs0_dat.size() > 0 && obs0_dat[0] !== -32768) begin
            errors++;
            $display("FAIL avg0_negsat: got %0d, expected -32768", obs0_dat[0]);
        end
        while (exp0_cyc.size() > 0 && obs0_cyc.size() > 0) begin
            ec = exp0_cyc.pop_front(); ed = exp0_dat.pop_front();
            oc = obs0_cyc.pop_front(); od = obs0_dat.pop_front();
            checks++;
            if ({oc, od} !== {ec, ed}) begin
                errors++;
                $display("FAIL avg0_result: got cyc=%0d d=%0d, expected cyc=%0d d=%0d", oc, od, ec, ed);
            end
        end
    endtask

    task automatic test_fault();
        do_reset();
        off[0] = 8'd0; gn[0] = 16'd16; lim[0] = 16'sd50;
        off[1] = 8'd0; gn[1] = 16'd16; lim[1] = 16'sd10;
        repeat (16) send(1'b1, 0, 100);
        idle(4);
        checks++;
        if (o_fault !== 2'b01) begin
            errors++;
            $display("FAIL fault_set: got %b, expected 01", o_fault);
        end
        idle(5);
        checks++;
        if (o_fault !== 2'b01) begin
            errors++;
            $display("FAIL fault_sticky: got %b, expected 01", o_fault);
        end
        repeat (16) send(1'b1, 1, 20);
        idle(4);
        checks++;
        if (o_fault !== 2'b11) begin
            errors++;
            $display("FAIL fault_ch1: got %b, expected 11", o_fault);
        end
        repeat (16) send(1'b1, 0, 100);
        idle(1);
        i_clear = 1'b1;
        @(negedge clock);
        i_clear = 1'b0;
        checks++;
        if ({o_valid, o_fault} !== 3'b101) begin
            errors++;
            $display("FAIL fault_clear_race: got v=%b f=%b, expected v=1 f=01", o_valid, o_fault);
        end
        idle(2);
        i_clear = 1'b1;
        @(negedge clock);
        i_clear = 1'b0;
        checks++;
        if (o_fault !== 2'b00) begin
            errors++;
            $display("FAIL fault_clear: got %b, expected 00", o_fault);
        end
    endtask

    task automatic test_reset_mid();
        int ec, ech, ed, oc, och, od;
        do_reset();
        off[0] = 8'd0; gn[0] = 16'd16; lim[0] = 16'sd32767;
        off[1] = 8'd0; gn[1] = 16'd16; lim[1] = 16'sd0;
        repeat (8) send(1'b1, 0, 200);
        repeat (16) send(1'b1, 1, 90);
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        clear_model();
        idle(4);
        checks++;
        if (obs_cyc.size() !== 0 || {o_data, o_data_all, o_fault} !== '0) begin
            errors++;
            $display("FAIL reset_mid_discard: got %0d results d=%h all=%h f=%b, expected none and zero",
                     obs_cyc.size(), o_data, o_data_all, o_fault);
        end
        obs_cyc.delete(); obs_ch.delete(); obs_dat.delete();
        repeat (16) send(1'b1, 0, 40);
        idle(4);
        checks++;
        if (obs_cyc.size() !== 1) begin
            errors++;
            $display("FAIL reset_mid_count: got %0d results, expected 1", obs_cyc.size());
        end
        while (exp_cyc.size() > 0 && obs_cyc.size() > 0) begin
            ec = exp_cyc.pop_front(); ech = exp_ch.pop_front(); ed = exp_dat.pop_front();
            oc = obs_cyc.pop_front(); och = obs_ch.pop_front(); od = obs_dat.pop_front();
            checks++;
            if ({oc, och, od} !== {ec, ech, ed} || od !== 40) begin
                errors++;
                $display("FAIL reset_mid_result: got cyc=%0d ch=%0d d=%0d, expected cyc=%0d ch=%0d d=%0d",
                         oc, och, od, ec, ech, ed);
            end
        end
    endtask

    task automatic test_ignore();
        int ec, ech, ed, oc, och, od;
        do_reset();
        off[0] = 8'd0; gn[0] = 16'd16; lim[0] = 16'sd32767;
        repeat (5) send(1'b1, 0, 40);
        send(1'b1, 2, 255);
        send(1'b1, 7, 255);
        for (int i = 0; i < 4; i++) send(1'b0, 0, $urandom_range(0, 255));
        send(1'b1, 2, 250);
        repeat (11) send(1'b1, 0, 40);
        idle(4);
        checks++;
        if (obs_cyc.size() !== 1) begin
            errors++;
            $display("FAIL ignore_count: got %0d results, expected 1", obs_cyc.size());
        end
        while (exp_cyc.size() > 0 && obs_cyc.size() > 0) begin
            ec = exp_cyc.pop_front(); ech = exp_ch.pop_front(); ed = exp_dat.pop_front();
            oc = obs_cyc.pop_front(); och = obs_ch.pop_front(); od = obs_dat.pop_front();
            checks++;
            if ({oc, och, od} !== {ec, ech, ed} || od !== 40) begin
                errors++;
                $display("FAIL ignore_result: got cyc=%0d ch=%0d d=%0d, expected cyc=%0d ch=%0d d=%0d",
                         oc, och, od, ec, ech, ed);
            end
        end
    endtask

    task automatic test_back_to_back();
        int ec, ech, ed, oc, och, od;
        do_reset();
        for (int k = 0; k < 2; k++) begin
            off[k] = 8'($urandom_range(0, 255));
            gn[k]  = 16'($urandom_range(0, 4095));
            lim[k] = 16'sd32767;
        end
        for (int i = 0; i < 15; i++) begin
            send(1'b1, 0, $urandom_range(0, 255));
            send(1'b1, 1, $urandom_range(0, 255));
        end
        send(1'b1, 0, $urandom_range(0, 255));
        send(1'b1, 1, $urandom_range(0, 255));
        idle(4);
        checks++;
        if (obs_cyc.size() !== 2 || (obs_cyc.size() == 2 && obs_cyc[1] - obs_cyc[0] !== 1)) begin
            errors++;
            $display("FAIL b2b_spacing: got %0d results, expected 2 on adjacent cycles", obs_cyc.size());
        end
        while (exp_cyc.size() > 0 && obs_cyc.size() > 0) begin
            ec = exp_cyc.pop_front(); ech = exp_ch.pop_front(); ed = exp_dat.pop_front();
            oc = obs_cyc.pop_front(); och = obs_ch.pop_front(); od = obs_dat.pop_front();
            checks++;
            if ({oc, och, od} !== {ec, ech, ed}) begin
                errors++;
                $display("FAIL b2b_result: got cyc=%0d ch=%0d d=%0d, expected cyc=%0d ch=%0d d=%0d",
                         oc, och, od, ec, ech, ed);
            end
        end
    endtask

    task automatic test_random();
        int ec, ech, ed, oc, och, od;
        do_reset();
        for (int k = 0; k < 2; k++) begin
            off[k] = 8'($urandom_range(0, 255));
            gn[k]  = 16'($urandom_range(0, 65535));
            lim[k] = 16'($urandom_range(0, 65535));
        end
        for (int i = 0; i < 600; i++) begin
            send($urandom_range(0, 3) != 0, $urandom_range(0, 2), $urandom_range(0, 255));
        end
        idle(4);
        checks++;
        if (obs_cyc.size() !== exp_cyc.size()) begin
            errors++;
            $display("FAIL random_count: got %0d results, expected %0d", obs_cyc.size(), exp_cyc.size());
        end
        while (exp_cyc.size() > 0 && obs_cyc.size() > 0) begin
            ec = exp_cyc.pop_front(); ech = exp_ch.pop_front(); ed = exp_dat.pop_front();
            oc = obs_cyc.pop_front(); och = obs_ch.pop_front(); od = obs_dat.pop_front();
            checks++;
            if ({oc, och, od} !== {ec, ech, ed}) begin
                errors++;
                $display("FAIL random_result: got cyc=%0d ch=%0d d=%0d, expected cyc=%0d ch=%0d d=%0d",
                         oc, och, od, ec, ech, ed);
            end
        end
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (int'($signed(o_data_all[k*16 +: 16])) !== m_all[k]) begin
                errors++;
                $display("FAIL random_hold ch%0d: got %0d, expected %0d",
                         k, $signed(o_data_all[k*16 +: 16]), m_all[k]);
            end
        end
        checks++;
        if (o_fault !== m_fault) begin
            errors++;
            $display("FAIL random_fault: got %b, expected %b", o_fault, m_fault);
        end
    endtask

    initial begin
        off[0] = '0; off[1] = '0;
        gn[0]  = '0; gn[1]  = '0;
        lim[0] = '0; lim[1] = '0;
        test_reset();
        test_basic();
        test_interleave();
        test_saturation();
        test_avg0();
        test_fault();
        test_reset_mid();
        test_ignore();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
